seven_segment_reader: RTL

- Reads back a multiplexed 4-digit seven-segment display bus: segment lines plus one-hot anode selects.
- Captures each digit's pattern once it has settled, then requires it to repeat across consecutive scans before accepting it.
- Decodes accepted patterns to 4-bit values and publishes them with a valid/ready update handshake.
- Sits on the display pins, after the segment driver, as a self-check and loopback monitor.

---
 rtl/seven_segment_pkg.sv | 31 +++
 rtl/seven_segment_pattern_decode.sv | 29 ++
 rtl/seven_segment_reader.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/seven_segment_pkg.sv
// Shared constants for the seven-segment readback monitor: segment bit positions,
// legal numeral codes (abcdefg order) and the digit count.
package seven_segment_pkg;

   localparam int NUM_DIGITS = 4;

   localparam int SEG_DP = 7;
   localparam int SEG_A  = 6;
   localparam int SEG_B  = 5;
   localparam int SEG_C  = 4;
   localparam int SEG_D  = 3;
   localparam int SEG_E  = 2;
   localparam int SEG_F  = 1;
   localparam int SEG_G  = 0;

   localparam logic [6:0] SEG_CODE_0 = 7'b1111110;
   localparam logic [6:0] SEG_CODE_1 = 7'b0110000;
   localparam logic [6:0] SEG_CODE_2 = 7'b1101101;
   localparam logic [6:0] SEG_CODE_3 = 7'b1111001;
   localparam logic [6:0] SEG_CODE_4 = 7'b0110011;
   localparam logic [6:0] SEG_CODE_5 = 7'b1011011;
   localparam logic [6:0] SEG_CODE_6 = 7'b1011111;
   localparam logic [6:0] SEG_CODE_7 = 7'b1110000;
   localparam logic [6:0] SEG_CODE_8 = 7'b1111111;
   localparam logic [6:0] SEG_CODE_9 = 7'b1111011;

   function automatic logic is_onehot(input logic [NUM_DIGITS-1:0] v);
      return (v != '0) && ((v & (v - 1'b1)) == '0);
   endfunction

endpackage

// File: rtl/seven_segment_pattern_decode.sv
// Combinational decode of a 7-bit abcdefg pattern to its numeral value;
// legal is low for any pattern that is not one of the ten numerals.
module seven_segment_pattern_decode
   import seven_segment_pkg::*;
(
   input  logic [6:0] pattern,
   output logic [3:0] value,
   output logic       legal
);

   always_comb begin
      value = 4'd0;
      legal = 1'b1;
      case (pattern)
         SEG_CODE_0: value = 4'd0;
         SEG_CODE_1: value = 4'd1;
         SEG_CODE_2: value = 4'd2;
         SEG_CODE_3: value = 4'd3;
         SEG_CODE_4: value = 4'd4;
         SEG_CODE_5: value = 4'd5;
         SEG_CODE_6: value = 4'd6;
         SEG_CODE_7: value = 4'd7;
         SEG_CODE_8: value = 4'd8;
         SEG_CODE_9: value = 4'd9;
         default:    legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/seven_segment_reader.sv
// Monitors a multiplexed 4-digit seven-segment bus and publishes debounced digit values.
// Define SEVEN_SEGMENT_READER_DP_EN to include the decimal point in capture and publish.
module seven_segment_reader
   import seven_segment_pkg::*;
#(
   parameter int SETTLE       = 4,
   parameter int STABLE_SCANS = 2
)
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic [7:0]              seg,
   input  logic [NUM_DIGITS-1:0]   an,
   output logic [4*NUM_DIGITS-1:0] digit,
   output logic [NUM_DIGITS-1:0]   err,
   output logic [NUM_DIGITS-1:0]   dp,
   output logic                    upd_valid,
   input  logic                    upd_ready
);

`ifdef SEVEN_SEGMENT_READER_DP_EN
   localparam int CW = 8;
`else
   localparam int CW = 7;
`endif
   localparam int EW = $clog2(SETTLE + 1);
   localparam int SW = $clog2(STABLE_SCANS + 1);

   logic [7:0]            seg_q;
   logic [NUM_DIGITS-1:0] an_q;
   logic [NUM_DIGITS-1:0] an_last_reg;
   logic [EW-1:0]         ep_cnt_reg;
   logic [EW-1:0]         ep_cnt_next;
   logic                  an_valid;
   logic                  capture;
   logic [CW-1:0]         cap;
   logic [3:0]            dec_value;
   logic                  dec_legal;
   logic [NUM_DIGITS-1:0] pub_change;
   logic                  upd_valid_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         seg_q       <= '0;
         an_q        <= '0;
         an_last_reg <= '0;
         ep_cnt_reg  <= '0;
      end else begin
         seg_q       <= seg;
         an_q        <= an;
         an_last_reg <= an_q;
         ep_cnt_reg  <= ep_cnt_next;
      end
   end

   // Count value for the current cycle: 0 on the first cycle of a fresh one-hot
   // selection, saturating at SETTLE so the capture point is hit once per episode.
   always_comb begin
      ep_cnt_next = '0;
      if (an_valid && (an_q == an_last_reg))
         ep_cnt_next = (ep_cnt_reg == EW'(SETTLE)) ? ep_cnt_reg : ep_cnt_reg + EW'(1);
   end

   assign an_valid = is_onehot(an_q);
   assign capture  = an_valid && (ep_cnt_next == EW'(SETTLE - 1));
   assign cap      = seg_q[CW-1:0];

`ifndef SEVEN_SEGMENT_READER_DP_EN
   logic unused_seg_dp;
   assign unused_seg_dp = seg_q[SEG_DP];
`endif

   seven_segment_pattern_decode u_decode (
      .pattern (seg_q[6:0]),
      .value   (dec_value),
      .legal   (dec_legal)
   );

   genvar gi;
   generate
      for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
         logic [CW-1:0] cand_reg;
         logic [SW-1:0] cnt_reg;
         logic [SW-1:0] cnt_next;
         logic [3:0]    digit_reg;
         logic [3:0]    value_next;
         logic          err_reg;
         logic          err_next;
         logic          dp_diff;
         logic          hit;
         logic          publish;
         logic          change;

         always_comb begin
            hit = capture && an_q[gi];
            if (cap == cand_reg)
               cnt_next = (cnt_reg == SW'(STABLE_SCANS)) ? cnt_reg : cnt_reg + SW'(1);
            else
               cnt_next = SW'(1);
            publish    = hit && (cnt_next == SW'(STABLE_SCANS));
            value_next = dec_legal ? dec_value : digit_reg;
            err_next   = ~dec_legal;
            change     = publish && ((value_next != digit_reg) || (err_next != err_reg) || dp_diff);
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               cand_reg  <= '0;
               cnt_reg   <= '0;
               digit_reg <= '0;
               err_reg   <= 1'b0;
            end else begin
               if (hit) begin
                  cand_reg <= cap;
                  cnt_reg  <= cnt_next;
               end
               if (change) begin
                  digit_reg <= value_next;
                  err_reg   <= err_next;
               end
            end
         end

`ifdef SEVEN_SEGMENT_READER_DP_EN
         logic dp_reg;
         assign dp_diff = (dp_reg != seg_q[SEG_DP]);
         always_ff @(posedge clk) begin
            if (rst)
               dp_reg <= 1'b0;
            else if (change)
               dp_reg <= seg_q[SEG_DP];
         end
         assign dp[gi] = dp_reg;
`else
         assign dp_diff = 1'b0;
         assign dp[gi]  = 1'b0;
`endif

         assign digit[4*gi +: 4] = digit_reg;
         assign err[gi]          = err_reg;
         assign pub_change[gi]   = change;
      end
   endgenerate

   // A changing publish wins over an acknowledge in the same cycle.
   always_ff @(posedge clk) begin
      if (rst)
         upd_valid_reg <= 1'b0;
      else if (|pub_change)
         upd_valid_reg <= 1'b1;
      else if (upd_valid_reg && upd_ready)
         upd_valid_reg <= 1'b0;
   end

   assign upd_valid = upd_valid_reg;

endmodule
